// File: rtl/wam_round_engine.sv
`default_nettype none
// ============================================================================
// Module   : wam_round_engine
// Brief    : Whack-a-mole round FSM: gap/lit phasing, non-repeating LFSR
//            target selection and saturating hit/miss scoring.
// Revision : 1.0
// ============================================================================
module wam_round_engine #(
    parameter int          NUM_LIGHTS = 9,
    parameter int          CNT_W      = 28,
    parameter int          BASE_GAP   = 50000000,
    parameter int          BASE_ON    = 50000000,
    parameter int          SCORE_W    = 8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            level,
    input  logic [NUM_LIGHTS-1:0] btn,
    output logic [NUM_LIGHTS-1:0] leds,
    output logic [3:0]            active_idx,
    output logic                  hit_pulse,
    output logic                  miss_pulse,
    output logic [SCORE_W-1:0]    hits,
    output logic [SCORE_W-1:0]    misses
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_SHOW = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]      c_base_gap = CNT_W'(BASE_GAP);
    localparam logic [CNT_W-1:0]      c_base_on  = CNT_W'(BASE_ON);
    localparam logic [15:0]           c_num      = 16'(NUM_LIGHTS);
    localparam logic [3:0]            c_last_idx = 4'(NUM_LIGHTS - 1);
    localparam logic [NUM_LIGHTS-1:0] c_one      = NUM_LIGHTS'(1);

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [NUM_LIGHTS-1:0] r_leds, w_leds_nxt;
    logic [3:0]            r_active_idx, w_active_idx_nxt;
    logic                  r_hit_pulse, w_hit_pulse_nxt;
    logic                  r_miss_pulse, w_miss_pulse_nxt;
    logic [SCORE_W-1:0]    r_hits, w_hits_nxt;
    logic [SCORE_W-1:0]    r_misses, w_misses_nxt;
    logic [15:0]           r_lfsr;

    logic [CNT_W-1:0]      w_gap_shift, w_on_shift, w_gap_reload, w_on_reload;
    logic                  w_lfsr_fb;
    logic [3:0]            w_cand, w_target;
    logic                  w_btn_hit, w_btn_other;

    // A phase that shifts down to zero is clamped to one cycle, i.e. a reload of zero.
    assign w_gap_shift  = c_base_gap >> level;
    assign w_on_shift   = c_base_on >> level;
    assign w_gap_reload = (w_gap_shift == '0) ? '0 : w_gap_shift - CNT_W'(1);
    assign w_on_reload  = (w_on_shift == '0) ? '0 : w_on_shift - CNT_W'(1);

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_cand    = 4'(r_lfsr % c_num);

    always_comb begin
        w_target = w_cand;
        if (NUM_LIGHTS > 1 && w_cand == r_active_idx)
            w_target = (w_cand == c_last_idx) ? 4'd0 : w_cand + 4'd1;
    end

    // In SHOW the lit pattern is exactly the one-hot of the target, so it doubles as the button mask.
    assign w_btn_hit   = |(btn & r_leds);
    assign w_btn_other = |(btn & ~r_leds);

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_leds_nxt       = r_leds;
        w_active_idx_nxt = r_active_idx;
        w_hit_pulse_nxt  = 1'b0;
        w_miss_pulse_nxt = 1'b0;
        w_hits_nxt       = r_hits;
        w_misses_nxt     = r_misses;
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_leds_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = w_gap_reload;
                    w_leds_nxt  = '0;
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        w_state_nxt      = S_SHOW;
                        w_active_idx_nxt = w_target;
                        w_leds_nxt       = c_one << w_target;
                        w_cnt_nxt        = w_on_reload;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                S_SHOW: begin
                    if (w_btn_hit) begin
                        w_hit_pulse_nxt = 1'b1;
                        w_hits_nxt      = (&r_hits) ? r_hits : r_hits + SCORE_W'(1);
                        w_leds_nxt      = '0;
                        w_state_nxt     = S_GAP;
                        w_cnt_nxt       = w_gap_reload;
                    end else if (w_btn_other || r_cnt == '0) begin
                        w_miss_pulse_nxt = 1'b1;
                        w_misses_nxt     = (&r_misses) ? r_misses : r_misses + SCORE_W'(1);
                        w_leds_nxt       = '0;
                        w_state_nxt      = S_GAP;
                        w_cnt_nxt        = w_gap_reload;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_leds_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_leds       <= '0;
            r_active_idx <= 4'd0;
            r_hit_pulse  <= 1'b0;
            r_miss_pulse <= 1'b0;
            r_hits       <= '0;
            r_misses     <= '0;
            r_lfsr       <= LFSR_SEED;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_leds       <= w_leds_nxt;
            r_active_idx <= w_active_idx_nxt;
            r_hit_pulse  <= w_hit_pulse_nxt;
            r_miss_pulse <= w_miss_pulse_nxt;
            r_hits       <= w_hits_nxt;
            r_misses     <= w_misses_nxt;
            r_lfsr       <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    assign leds       = r_leds;
    assign active_idx = r_active_idx;
    assign hit_pulse  = r_hit_pulse;
    assign miss_pulse = r_miss_pulse;
    assign hits       = r_hits;
    assign misses     = r_misses;

endmodule
`default_nettype wire

// File: tb/tb_wam_round_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_wam_round_engine
// Brief    : Self-checking bench for wam_round_engine against a cycle-level
//            behavioural model of the game rules.
// Revision : 1.0
// ============================================================================
module tb_wam_round_engine;
    localparam int          N         = 4;
    localparam int          CNT_W     = 8;
    localparam int          BASE_GAP  = 8;
    localparam int          BASE_ON   = 8;
    localparam int          SCORE_W   = 2;
    localparam int          SCORE_MAX = (1 << SCORE_W) - 1;
    localparam logic [15:0] SEED      = 16'hACE1;
    localparam logic [15:0] TAP_MASK  = 16'hB400;   // taps 16,14,13,11

    logic               clk = 1'b0;
    logic               reset, enable;
    logic [1:0]         level;
    logic [N-1:0]       btn;
    logic [N-1:0]       leds;
    logic [3:0]         active_idx;
    logic               hit_pulse, miss_pulse;
    logic [SCORE_W-1:0] hits, misses;

    int total = 0;
    int bad   = 0;

    // Model: phase 0 idle, 1 gap, 2 show; m_left = cycles still to spend in the phase.
    int          m_phase = 0, m_left = 0, m_idx = 0, m_hits = 0, m_misses = 0;
    int          m_hp = 0, m_mp = 0;
    logic [15:0] m_lfsr = SEED;

    always #5 clk = ~clk;

    wam_round_engine #(
        .NUM_LIGHTS(N), .CNT_W(CNT_W), .BASE_GAP(BASE_GAP), .BASE_ON(BASE_ON),
        .SCORE_W(SCORE_W), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .level(level), .btn(btn),
        .leds(leds), .active_idx(active_idx), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .hits(hits), .misses(misses)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], ^(x & TAP_MASK)};
    endfunction

    function automatic int len_of(input int base, input logic [1:0] lv);
        int v;
        v = base >> lv;
        return (v < 1) ? 1 : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model_step();
        logic [15:0] prev;
        int t;
        prev   = m_lfsr;
        m_lfsr = lfsr_step(m_lfsr);
        m_hp   = 0;
        m_mp   = 0;
        if (reset) begin
            m_phase = 0; m_left = 0; m_idx = 0; m_hits = 0; m_misses = 0; m_lfsr = SEED;
        end else if (!enable) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
            m_left  = len_of(BASE_GAP, level);
        end else if (m_phase == 1) begin
            if (m_left > 1) m_left--;
            else begin
                t = int'(prev) % N;
                if (t == m_idx) t = (t + 1) % N;
                m_idx   = t;
                m_phase = 2;
                m_left  = len_of(BASE_ON, level);
            end
        end else begin
            if (((btn >> m_idx) & N'(1)) != '0) begin
                m_hp = 1;
                if (m_hits < SCORE_MAX) m_hits++;
            end else if (btn != '0 || m_left == 1) begin
                m_mp = 1;
                if (m_misses < SCORE_MAX) m_misses++;
            end else m_left--;
            if (m_hp == 1 || m_mp == 1) begin
                m_phase = 1;
                m_left  = len_of(BASE_GAP, level);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("leds", leds, (m_phase == 2) ? (N'(1) << m_idx) : '0);
        check("active_idx", active_idx, m_idx);
        check("hit_pulse", hit_pulse, m_hp);
        check("miss_pulse", miss_pulse, m_mp);
        check("hits", hits, m_hits);
        check("misses", misses, m_misses);
    endtask

    task automatic wait_lit(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (leds == '0 && n < 200);
        check("lit_reached", leds != '0, 1);
    endtask

    task automatic count_lit(output int n);
        n = 1;
        tick();
        while (leds != '0 && n < 200) begin
            n++;
            tick();
        end
        check("lit_ended", leds == '0, 1);
    endtask

    task automatic press(input logic [N-1:0] bits);
        btn = bits;
        tick();
        btn = '0;
    endtask

    initial begin
        int         n;
        logic [3:0] prev;
        logic [3:0] seen;
        int         exp_miss[5];
        exp_miss = '{1, 2, 3, 3, 3};

        reset = 1'b1; enable = 1'b0; level = 2'd0; btn = '0;
        tick(); tick();
        check("rst_leds", leds, 0);
        check("rst_idx", active_idx, 0);
        check("rst_pulses", {hit_pulse, miss_pulse}, 0);
        check("rst_scores", {hits, misses}, 0);
        reset = 1'b0;

        // Timeout miss: one edge leaves IDLE, then 8 gap cycles, 8 lit cycles.
        enable = 1'b1;
        wait_lit(n);  check("t1_gap", n, 9);
        count_lit(n); check("t1_on", n, 8);
        check("t1_miss_pulse", miss_pulse, 1);
        check("t1_misses", misses, 1);
        check("t1_hits", hits, 0);

        // Hit on the third lit cycle.
        wait_lit(n); check("t2_gap", n, 8);
        tick(); tick();
        press(N'(1) << m_idx);
        check("t2_leds", leds, 0);
        check("t2_hit_pulse", hit_pulse, 1);
        check("t2_hits", hits, 1);
        wait_lit(n); check("t2_next_gap", n, 8);

        // Level 3: single-cycle gap and lit phases.
        enable = 1'b0; tick();
        level = 2'd3; enable = 1'b1; tick();
        wait_lit(n); check("t2_l3_gap", n, 1);
        press(N'(1) << m_idx);
        check("t2_l3_hit", hit_pulse, 1);
        check("t2_l3_hits", hits, 2);
        level = 2'd0;

        // Arbitration.
        wait_lit(n);
        press(N'(1) << ((m_idx + 1) % N));
        check("t3_wrong_miss", miss_pulse, 1);
        check("t3_wrong_misses", misses, 2);
        check("t3_wrong_hits", hits, 2);
        wait_lit(n);
        press((N'(1) << m_idx) | (N'(1) << ((m_idx + 1) % N)));
        check("t3_both_hit", hit_pulse, 1);
        check("t3_both_nomiss", miss_pulse, 0);
        check("t3_both_hits", hits, 3);
        btn = '1;
        repeat (3) begin
            tick();
            check("t3_gap_pulses", {hit_pulse, miss_pulse}, 0);
        end
        check("t3_gap_scores", {hits, misses}, {2'd3, 2'd2});
        enable = 1'b0;
        repeat (3) begin
            tick();
            check("t3_idle_pulses", {hit_pulse, miss_pulse}, 0);
        end
        check("t3_idle_scores", {hits, misses}, {2'd3, 2'd2});
        btn = '0;

        // Saturation and target randomness.
        reset = 1'b1; tick(); reset = 1'b0; enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_lit(n);
            count_lit(n);
            check("t4_misses_sat", misses, exp_miss[k]);
        end
        level = 2'd3;
        prev  = active_idx;
        seen  = 4'd0;
        for (int r = 0; r < 1000; r++) begin
            wait_lit(n);
            check("t4_idx_range", active_idx < 4, 1);
            check("t4_idx_repeat", active_idx != prev, 1);
            prev = active_idx;
            seen = seen | (4'd1 << active_idx);
            tick();
        end
        check("t4_all_seen", seen, 4'hF);

        // Reset and disable mid-round.
        level = 2'd0;
        reset = 1'b1; tick(); reset = 1'b0;
        wait_lit(n); press(N'(1) << m_idx);
        wait_lit(n); press(N'(1) << m_idx);
        check("t5_hits2", hits, 2);
        wait_lit(n); tick();
        reset = 1'b1; tick();
        check("t5_rst_leds", leds, 0);
        check("t5_rst_idx", active_idx, 0);
        check("t5_rst_pulses", {hit_pulse, miss_pulse}, 0);
        check("t5_rst_scores", {hits, misses}, 0);
        reset = 1'b0;
        wait_lit(n); check("t5_post_rst_gap", n, 9);
        press(N'(1) << m_idx);
        wait_lit(n); tick();
        enable = 1'b0; tick();
        check("t5_dis_leds", leds, 0);
        check("t5_dis_pulses", {hit_pulse, miss_pulse}, 0);
        check("t5_dis_scores", {hits, misses}, {2'd1, 2'd0});
        enable = 1'b1;
        wait_lit(n); check("t5_reen_gap", n, 9);

        // Level change in the middle of a gap.
        count_lit(n);
        repeat (3) tick();
        level = 2'd2;
        wait_lit(n);  check("t6_gap_rest", n, 8 - 3);
        count_lit(n); check("t6_on", n, 2);
        wait_lit(n);  check("t6_gap", n, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
